load_store_unit: RTL and testbench

- Requester side of the data-memory port. Sits between the CPU execute/memory stage and the byte-lane data RAM.
- Takes one load or store request per handshake (RV32I LB/LH/LW/LBU/LHU/SB/SH/SW) and converts it into word-indexed RAM beats with byte enables.
- Formats load data with sign or zero extension and returns a single-cycle response pulse.
- Data window is 0x00001000–0x00001FFF, little-endian: byte offset 0 maps to bits [7:0].

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_load_align.sv | 27 ++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared funct3 encodings, FSM state type and size/legality helpers for load_store_unit.
// Misaligned split support is selected in the top by LSU_MISALIGN_SPLIT_EN.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE0,
        S_ISSUE1,
        S_WAIT,
        S_RESP
    } lsu_state_t;

    // Access size in bytes from funct3[1:0]; the unsigned bit does not affect size.
    function automatic logic [2:0] size_from_funct3(input logic [1:0] f3_size);
        case (f3_size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data formatter: shifts the two-beat window by the byte offset and sign/zero extends.
// Purely combinational, no latency, no flow control.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] i_beats,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_sh;

    assign w_sh = 32'(i_beats >> {i_off, 3'b000});

    always_comb begin
        o_data = w_sh;
        case (i_funct3)
            F3_B:    o_data = {{24{w_sh[7]}}, w_sh[7:0]};
            F3_BU:   o_data = {24'h0, w_sh[7:0]};
            F3_H:    o_data = {{16{w_sh[15]}}, w_sh[15:0]};
            F3_HU:   o_data = {16'h0, w_sh[15:0]};
            default: o_data = w_sh;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store requester to a word-indexed byte-lane RAM; response 1-3 cycles after accept.
// One request in flight (req_ready only in IDLE); responses never stall. Option: LSU_MISALIGN_SPLIT_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_1000,
    parameter int          ADDRESS_WIDTH = 12,
    parameter int          DATA_WIDTH    = 32
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_store,
    input  logic [2:0]               req_funct3,
    input  logic [31:0]              req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic                     resp_fault,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-3:0] mem_addr,
    output logic [3:0]               mem_be,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd
);

    localparam logic [32:0] LP_LAST = {1'b0, BASE_ADDR} + (33'd1 << ADDRESS_WIDTH) - 33'd1;
    localparam logic [ADDRESS_WIDTH-3:0] LP_WORD_ONE = 1;

    lsu_state_t r_state, w_state_nxt;

    logic                     r_store, r_split;
    logic [2:0]               r_funct3;
    logic [1:0]               r_off;
    logic [ADDRESS_WIDTH-3:0] r_word;
    logic [3:0]               r_be0, r_be1;
    logic [DATA_WIDTH-1:0]    r_wd0, r_wd1, r_beat0;
    logic                     r_resp_valid, r_resp_fault;
    logic [DATA_WIDTH-1:0]    r_resp_rdata;

    logic                     w_accept, w_fault, w_split, w_oob, w_resp_set;
    logic [2:0]               w_size;
    logic [1:0]               w_off;
    logic [3:0]               w_size_mask;
    logic [7:0]               w_mask;
    logic [32:0]              w_last;
    logic [2*DATA_WIDTH-1:0]  w_wd_sh;
    logic [ADDRESS_WIDTH-3:0] w_word;
    logic [DATA_WIDTH-1:0]    w_fmt;

    assign w_accept    = req_valid && req_ready;
    assign w_size      = size_from_funct3(req_funct3[1:0]);
    assign w_off       = req_addr[1:0];
    assign w_last      = {1'b0, req_addr} + {30'd0, w_size} - 33'd1;
    assign w_oob       = (req_addr < BASE_ADDR) || (w_last > LP_LAST);
    assign w_size_mask = (w_size == 3'd1) ? 4'h1 : ((w_size == 3'd2) ? 4'h3 : 4'hF);
    assign w_mask      = {4'h0, w_size_mask} << w_off;
    assign w_wd_sh     = {{DATA_WIDTH{1'b0}}, req_wdata} << {w_off, 3'b000};
    assign w_word      = req_addr[ADDRESS_WIDTH-1:2] - BASE_ADDR[ADDRESS_WIDTH-1:2];

`ifdef LSU_MISALIGN_SPLIT_EN
    assign w_split = ({1'b0, w_off} + w_size) > 3'd4;
    assign w_fault = !funct3_legal(req_store, req_funct3) || w_oob;
`else
    assign w_split = 1'b0;
    assign w_fault = !funct3_legal(req_store, req_funct3) || w_oob ||
                     ((w_size == 3'd2) && w_off[0]) || ((w_size == 3'd4) && (w_off != 2'd0));
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = w_fault ? S_RESP : S_ISSUE0;
            S_ISSUE0: w_state_nxt = r_split ? S_ISSUE1 : (r_store ? S_IDLE : S_WAIT);
            S_ISSUE1: w_state_nxt = r_store ? S_IDLE : S_WAIT;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Beats are gated by rst so a reset cycle never commits a write.
    always_comb begin
        req_ready  = (r_state == S_IDLE) && !rst;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = r_word;
        mem_be     = 4'h0;
        mem_wd     = '0;
        w_resp_set = 1'b0;
        case (r_state)
            S_ISSUE0: begin
                mem_en     = !rst;
                mem_we     = r_store && !rst;
                mem_be     = r_store ? r_be0 : 4'hF;
                mem_wd     = r_wd0;
                w_resp_set = r_store && !r_split;
            end
            S_ISSUE1: begin
                mem_en     = !rst;
                mem_we     = r_store && !rst;
                mem_addr   = r_word + LP_WORD_ONE;
                mem_be     = r_store ? r_be1 : 4'hF;
                mem_wd     = r_wd1;
                w_resp_set = r_store;
            end
            S_WAIT, S_RESP: w_resp_set = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_store  <= req_store;
            r_funct3 <= req_funct3;
            r_off    <= w_off;
            r_word   <= w_word;
            r_be0    <= w_mask[3:0];
            r_be1    <= w_mask[7:4];
            r_wd0    <= w_wd_sh[DATA_WIDTH-1:0];
            r_wd1    <= w_wd_sh[2*DATA_WIDTH-1:DATA_WIDTH];
            r_split  <= w_split;
        end
        if (r_state == S_ISSUE1) r_beat0 <= mem_rd;
    end

    // In WAIT mem_rd holds the last beat; for unsplit loads it is also beat 0.
    lsu_load_align u_align (
        .i_beats  ({mem_rd, (r_split ? r_beat0 : mem_rd)}),
        .i_off    (r_off),
        .i_funct3 (r_funct3),
        .o_data   (w_fmt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= w_resp_set;
            r_resp_fault <= (r_state == S_RESP);
            r_resp_rdata <= (r_state == S_WAIT) ? w_fmt : '0;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_fault = r_resp_fault;
    assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a byte-lane RAM model; covers both LSU_MISALIGN_SPLIT_EN builds.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wd, mem_rd;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_fault(resp_fault), .resp_rdata(resp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // RAM model: one-cycle read latency, per-lane writes, plus a bench preload port.
    logic [31:0] mem [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [31:0] pre_dat = '0;
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_dat;
        if (mem_en && !mem_we) mem_rd <= mem[mem_addr];
        if (mem_en && mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wd[8*b +: 8];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    typedef struct { logic fault; logic [31:0] rdata; int lat; int acc; } exp_t;
    typedef struct packed { logic we; logic [9:0] addr; logic [3:0] be; logic [31:0] wd; } beat_t;

    exp_t  sb_q[$];
    beat_t beat_q[$];
    exp_t  m_e;
    int    cyc = 0;
    int    n_resp = 0;
    int    last_resp_cyc = -10;
    int    last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (mem_en) beat_q.push_back({mem_we, mem_addr, mem_be, mem_wd});

    always @(posedge clk) begin
        #1;
        if (resp_valid) begin
            n_resp++;
            last_resp_cyc = cyc;
            if (sb_q.size() == 0) chk("unexpected_resp", 64'(1), 64'(0));
            else begin
                m_e = sb_q.pop_front();
                chk("resp_fault", 64'(resp_fault), 64'(m_e.fault));
                chk("resp_rdata", 64'(resp_rdata), 64'(m_e.rdata));
                chk("resp_latency", 64'(cyc - m_e.acc), 64'(m_e.lat));
            end
        end
    end

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_dat = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic xf, input logic [31:0] xr, input int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 64'(0), 64'(1));
            req_valid = 1'b0;
            return;
        end
        sb_q.push_back('{fault: xf, rdata: xr, lat: lat, acc: cyc + 1});
        last_acc = cyc + 1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sb_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_resp_fault", 64'(resp_fault), 64'(0));
        chk("rst_resp_rdata", 64'(resp_rdata), 64'(0));
        chk("rst_mem_en", 64'(mem_en), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        preload(10'd0, 32'h80FF7F01);
        preload(10'd1, 32'h44332211);
        preload(10'd2, 32'h88776655);
        rst = 1'b0;

        // Byte loads from the top lane: whole-word read, sign vs zero extension
        beat_q.delete();
        do_req(1'b0, F3_B, 32'h1003, '0, 1'b0, 32'hFFFFFF80, 2);
        drain();
        chk("lb_beat_count", 64'(beat_q.size()), 64'(1));
        if (beat_q.size() > 0) begin
            chk("lb_be", 64'(beat_q[0].be), 64'(4'hF));
            chk("lb_addr", 64'(beat_q[0].addr), 64'(0));
        end
        do_req(1'b0, F3_BU, 32'h1003, '0, 1'b0, 32'h00000080, 2);
        drain();

        // Upper-half store then word readback
        beat_q.delete();
        do_req(1'b1, F3_H, 32'h1002, 32'h1234ABCD, 1'b0, 32'h0, 1);
        drain();
        chk("sh_beat_count", 64'(beat_q.size()), 64'(1));
        if (beat_q.size() > 0) begin
            chk("sh_we", 64'(beat_q[0].we), 64'(1));
            chk("sh_addr", 64'(beat_q[0].addr), 64'(0));
            chk("sh_be", 64'(beat_q[0].be), 64'(4'hC));
            chk("sh_wd", 64'(beat_q[0].wd), 64'(32'hABCD0000));
        end
        do_req(1'b0, F3_W, 32'h1000, '0, 1'b0, 32'hABCD7F01, 2);
        drain();

        // Word load straddling words 1 and 2
        beat_q.delete();
`ifdef LSU_MISALIGN_SPLIT_EN
        do_req(1'b0, F3_W, 32'h1006, '0, 1'b0, 32'h66554433, 3);
        drain();
        chk("split_beat_count", 64'(beat_q.size()), 64'(2));
        if (beat_q.size() > 1) begin
            chk("split_addr0", 64'(beat_q[0].addr), 64'(1));
            chk("split_addr1", 64'(beat_q[1].addr), 64'(2));
        end
`else
        do_req(1'b0, F3_W, 32'h1006, '0, 1'b1, 32'h0, 1);
        drain();
        chk("misal_no_beat", 64'(beat_q.size()), 64'(0));
`endif

        // Window and funct3 faults never touch memory
        beat_q.delete();
        do_req(1'b1, F3_W, 32'h1FFE, 32'h11111111, 1'b1, 32'h0, 1);
        do_req(1'b0, F3_W, 32'h2000, '0, 1'b1, 32'h0, 1);
        do_req(1'b0, F3_W, 32'h0FFC, '0, 1'b1, 32'h0, 1);
        do_req(1'b0, 3'b011, 32'h1000, '0, 1'b1, 32'h0, 1);
        do_req(1'b1, 3'b100, 32'h1000, 32'h22222222, 1'b1, 32'h0, 1);
        drain();
        chk("fault_no_beat", 64'(beat_q.size()), 64'(0));

        // Back-to-back loads: second accepted while first response is visible
        do_req(1'b0, F3_HU, 32'h1002, '0, 1'b0, 32'h0000ABCD, 2);
        do_req(1'b0, F3_H, 32'h1002, '0, 1'b0, 32'hFFFFABCD, 2);
        chk("b2b_gap", 64'(last_acc), 64'(last_resp_cyc + 1));
        do_req(1'b0, F3_W, 32'h1000, '0, 1'b0, 32'hABCD7F01, 2);
        chk("b2b_gap2", 64'(last_acc), 64'(last_resp_cyc + 1));
        drain();

        // Halfword store across the word 0/1 boundary
`ifdef LSU_MISALIGN_SPLIT_EN
        do_req(1'b1, F3_H, 32'h1003, 32'h0000BEEF, 1'b0, 32'h0, 2);
        do_req(1'b0, F3_W, 32'h1000, '0, 1'b0, 32'hEFCD7F01, 2);
        do_req(1'b0, F3_BU, 32'h1004, '0, 1'b0, 32'h000000BE, 2);
        drain();
`else
        do_req(1'b1, F3_H, 32'h1003, 32'h0000BEEF, 1'b1, 32'h0, 1);
        drain();
`endif

`ifdef LSU_MISALIGN_SPLIT_EN
        // Reset during the second beat of a split store
        preload(10'd1, 32'h44332211);
        preload(10'd2, 32'h88776655);
        snap = n_resp;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_W; req_addr = 32'h1007; req_wdata = 32'hDDCCBBAA;
        chk("rstmid_ready_before", 64'(req_ready), 64'(1));
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rstmid_ready_after", 64'(req_ready), 64'(1));
        repeat (4) @(negedge clk);
        chk("rstmid_word1", 64'(mem[1]), 64'(32'hAA332211));
        chk("rstmid_word2", 64'(mem[2]), 64'(32'h88776655));
        chk("rstmid_no_resp", 64'(n_resp - snap), 64'(0));
`else
        snap = n_resp;
        do_req(1'b1, F3_W, 32'h1007, 32'hDDCCBBAA, 1'b1, 32'h0, 1);
        drain();
        chk("misal_sw_one_resp", 64'(n_resp - snap), 64'(1));
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
